// File: rtl/count_pkg.sv
// ---------------------------------------------------------------------------
// count_pkg
// Shared types and constants for the count-seek controller slice.
//   state_t     : controller FSM states
//   CNT_WIDTH   : default counter/target width
//   HALF_RANGE  : half of the modular counter range (2^(CNT_WIDTH-1))
// ---------------------------------------------------------------------------
package count_pkg;

  localparam int CNT_WIDTH  = 16;
  localparam int HALF_RANGE = 2 ** (CNT_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    WAIT,
    STEP,
    DONE
  } state_t;

endpackage

// File: rtl/count_seek_ctrl_if.sv
// ---------------------------------------------------------------------------
// count_seek_ctrl_if
// Strobe/data bus between the seek controller and the up/down counter.
//   Up, Dw, LD : count-up, count-down and load strobes (controller -> counter)
//   d          : load data (controller -> counter)
//   q          : registered counter value (counter -> controller)
//   utc, dtc   : counter all-ones / all-zeros flags (counter -> controller)
// Modports: master = controller side, slave = counter side.
// ---------------------------------------------------------------------------
interface count_seek_ctrl_if
  import count_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
);

  logic             Up;
  logic             Dw;
  logic             LD;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             utc;
  logic             dtc;

  modport master (output Up, Dw, LD, d, input q, utc, dtc);
  modport slave  (input Up, Dw, LD, d, output q, utc, dtc);

endinterface

// File: rtl/count_seek_ctrl_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Loadable down-counter that paces the seek steps.
//   clock, reset_n : system clock, async active-low reset
//   i_load         : reload with TICK_DIV-1
//   i_dec          : count down by one (holds at zero)
//   o_zero         : counter is zero
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int PW = $clog2(TICK_DIV) + 1;

  logic [PW-1:0] r_cnt;

  // Reload takes priority so a fresh CHECK always restarts the full wait.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= PW'(TICK_DIV - 1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/count_seek_ctrl.sv
// ---------------------------------------------------------------------------
// count_seek_ctrl
// Drives an up/down counter one step at a time toward a requested target,
// always along the shorter modular direction, and pulses done on arrival.
// Also offers a direct-load path to the counter.
//   clock, reset_n : system clock, async active-low reset
//   start, target  : begin a seek (accepted in IDLE only)
//   load_req,
//   load_val       : direct counter load (accepted in IDLE, wins over start)
//   abort          : cancel an active seek
//   cnt            : counter bus (master side)
//   busy           : state is not IDLE
//   done           : one-cycle pulse when the seek reaches its target
//   steps          : strobes issued in the current/last seek
//   wrapped        : sticky, seek crossed the all-ones/all-zeros boundary
// ---------------------------------------------------------------------------
module count_seek_ctrl
  import count_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int TICK_DIV = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   target,
  input  logic               load_req,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               abort,
  count_seek_ctrl_if.master  cnt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   steps,
  output logic               wrapped
);

  // Half range widened by one bit so the comparison cannot overflow.
  localparam logic [WIDTH:0] W_HALF = {2'b01, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_steps;
  logic             r_wrapped;
  logic             r_dir;
  logic [WIDTH-1:0] w_diff;
  logic             w_dirUp;
  logic             w_atTarget;
  logic             w_tickZero;
  logic             w_up;
  logic             w_dw;
  logic             w_ld;

  // Modular distance to the target; an exact half-range tie goes up.
  assign w_diff     = r_tgt - cnt.q;
  assign w_dirUp    = ({1'b0, w_diff} <= W_HALF);
  assign w_atTarget = (cnt.q == r_tgt);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (r_state == CHECK),
    .i_dec   (r_state == WAIT),
    .o_zero  (w_tickZero)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort only matters while a seek is in progress.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (load_req) begin
          w_next = LOAD;
        end else if (start) begin
          w_next = CHECK;
        end
      end
      LOAD:  w_next = IDLE;
      CHECK: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_atTarget) begin
          w_next = DONE;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_tickZero) begin
          w_next = STEP;
        end
      end
      STEP: begin
        if (abort) begin
          w_next = IDLE;
        end else begin
          w_next = CHECK;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore output decode; the step strobes are additionally masked by abort
  // so a cancelled STEP never moves the counter.
  always_comb begin
    w_up = 1'b0;
    w_dw = 1'b0;
    w_ld = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (r_state)
      IDLE: busy = 1'b0;
      LOAD: w_ld = 1'b1;
      STEP: begin
        w_up = r_dir & ~abort;
        w_dw = ~r_dir & ~abort;
      end
      DONE: done = 1'b1;
      default: begin
        w_up = 1'b0;
        w_dw = 1'b0;
      end
    endcase
  end

  // Seek/load bookkeeping: captured operands, direction, step count and
  // the sticky wrap flag (utc/dtc still show the pre-step value in STEP).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tgt     <= '0;
      r_d       <= '0;
      r_steps   <= '0;
      r_wrapped <= 1'b0;
      r_dir     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_req) begin
            r_d <= load_val;
          end else if (start) begin
            r_tgt     <= target;
            r_steps   <= '0;
            r_wrapped <= 1'b0;
          end
        end
        CHECK: begin
          if (!abort && !w_atTarget) begin
            r_dir <= w_dirUp;
          end
        end
        STEP: begin
          if (!abort) begin
            r_steps <= r_steps + 1'b1;
            if ((w_up && cnt.utc) || (w_dw && cnt.dtc)) begin
              r_wrapped <= 1'b1;
            end
          end
        end
        default: begin
          r_steps <= r_steps;
        end
      endcase
    end
  end

  assign cnt.Up  = w_up;
  assign cnt.Dw  = w_dw;
  assign cnt.LD  = w_ld;
  assign cnt.d   = r_d;
  assign steps   = r_steps;
  assign wrapped = r_wrapped;

endmodule
